key_action_scheduler: RTL and testbench

- Sits between ps2_keyboard and the Tetris game FSM.
- Tracks which game keys are held from decoded make/break events and suppresses typematic repeats.
- Generates timed auto-repeat moves: DAS delay then ARR period for left/right, fixed period for soft drop.
- Queues one-hot game actions in a small FIFO that the game FSM drains with a valid/ready handshake.

---
 rtl/tetris_input_pkg.sv | 70 +++++++
 rtl/action_fifo.sv | 53 +++++
 rtl/key_action_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_key_action_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared types and constants for the keyboard-to-game input path.
package tetris_input_pkg;

    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_LEFT    = 3'd1,
        ACT_RIGHT   = 3'd2,
        ACT_SOFT    = 3'd3,
        ACT_HARD    = 3'd4,
        ACT_ROT_CW  = 3'd5,
        ACT_ROT_CCW = 3'd6,
        ACT_HOLD    = 3'd7
    } action_t;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_DAS  = 2'd1,
        H_ARR  = 2'd2
    } h_state_t;

    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LSHIFT = 8'h12;

    localparam int DEF_DAS_CYCLES  = 16000000;
    localparam int DEF_ARR_CYCLES  = 5000000;
    localparam int DEF_SOFT_CYCLES = 3000000;
    localparam int DEF_FIFO_DEPTH  = 4;

    localparam int NUM_KEYS = 7;

    // Scan code to game action; unmapped codes give ACT_NONE.
    function automatic action_t decode_key(input logic [7:0] sc);
        case (sc)
            SC_LEFT:   return ACT_LEFT;
            SC_RIGHT:  return ACT_RIGHT;
            SC_DOWN:   return ACT_SOFT;
            SC_UP:     return ACT_ROT_CW;
            SC_Z:      return ACT_ROT_CCW;
            SC_SPACE:  return ACT_HARD;
            SC_LSHIFT: return ACT_HOLD;
            default:   return ACT_NONE;
        endcase
    endfunction

    // Held-mask bit for an action: bit (code-1), ACT_NONE maps to no bit.
    function automatic logic [NUM_KEYS-1:0] key_bit(input action_t a);
        case (a)
            ACT_LEFT:    return 7'b000_0001;
            ACT_RIGHT:   return 7'b000_0010;
            ACT_SOFT:    return 7'b000_0100;
            ACT_HARD:    return 7'b000_1000;
            ACT_ROT_CW:  return 7'b001_0000;
            ACT_ROT_CCW: return 7'b010_0000;
            ACT_HOLD:    return 7'b100_0000;
            default:     return 7'b000_0000;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/action_fifo.sv
// Small synchronous FIFO of game actions; head is shown combinationally.
module action_fifo
    import tetris_input_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  logic [2:0] din,
    input  logic       pop,
    output logic [2:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    action_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? ACT_NONE : mem[rd_ptr[AW-1:0]];

    // Storage write; no reset needed since the output masks empty slots.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= action_t'(din);
    end

    // Pointer update with synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/key_action_scheduler.sv
// Turns make/break key events into queued one-hot game actions with
// DAS/ARR auto-repeat for left/right and periodic soft drop.
module key_action_scheduler
    import tetris_input_pkg::*;
#(
    parameter int DAS_CYCLES  = DEF_DAS_CYCLES,
    parameter int ARR_CYCLES  = DEF_ARR_CYCLES,
    parameter int SOFT_CYCLES = DEF_SOFT_CYCLES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] current_scan_code,
    input  logic       current_make_break,
    input  logic       key_event_valid,
    input  logic       enable,
    input  logic       flush,
    output logic [2:0] action,
    output logic       action_valid,
    input  logic       action_ready,
    output logic       overflow
);

    localparam int CNT_MAX = max3(DAS_CYCLES, ARR_CYCLES, SOFT_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DAS_LD  = CW'(DAS_CYCLES);
    localparam logic [CW-1:0] ARR_LD  = CW'(ARR_CYCLES);
    localparam logic [CW-1:0] SOFT_LD = CW'(SOFT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Key event decode
    action_t               ev_act;
    logic [NUM_KEYS-1:0]   ev_bit;
    logic                  ev_make;
    logic                  ev_brk;
    logic                  fresh;
    logic                  live;

    logic [NUM_KEYS-1:0]   held;

    h_state_t              h_state, h_state_n;
    logic [CW-1:0]         h_cnt, h_cnt_n;
    action_t               dir, dir_n;
    logic [CW-1:0]         s_cnt, s_cnt_n;

    action_t               opp_dir;
    logic                  opp_held;
    logic                  horiz_make;
    logic                  dir_brk;
    logic                  h_evt;
    logic                  s_evt;

    logic                  key_req;
    action_t               key_act;
    logic                  h_req;
    logic                  s_req;
    logic                  h_gnt;
    logic                  s_gnt;
    logic                  push_req;
    action_t               push_act;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    assign ev_act     = key_event_valid ? decode_key(current_scan_code) : ACT_NONE;
    assign ev_bit     = key_bit(ev_act);
    assign ev_make    = (ev_act != ACT_NONE) && current_make_break;
    assign ev_brk     = (ev_act != ACT_NONE) && !current_make_break;
    // Typematic repeats arrive as makes of an already-held key.
    assign fresh      = ev_make && ((held & ev_bit) == '0);
    assign live       = enable && !flush;

    assign opp_dir    = (dir == ACT_LEFT) ? ACT_RIGHT : ACT_LEFT;
    assign opp_held   = |(held & key_bit(opp_dir));
    assign horiz_make = fresh && ((ev_act == ACT_LEFT) || (ev_act == ACT_RIGHT));
    assign dir_brk    = ev_brk && (h_state != H_IDLE) && (ev_act == dir);
    assign h_evt      = horiz_make || dir_brk;
    assign s_evt      = (ev_act == ACT_SOFT) && (fresh || ev_brk);

    assign pop          = action_valid && action_ready;
    assign action_valid = !fifo_empty;

    // Held-key mask follows every mapped event, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            held <= '0;
        else if (ev_make)
            held <= held | ev_bit;
        else if (ev_brk)
            held <= held & ~ev_bit;
    end

    // Push arbitration: key event beats horizontal timer beats soft timer.
    always_comb begin
        key_req = 1'b0;
        key_act = ACT_NONE;
        if (fresh) begin
            key_req = 1'b1;
            key_act = ev_act;
        end else if (dir_brk && opp_held) begin
            key_req = 1'b1;
            key_act = opp_dir;
        end
        h_req    = (h_state != H_IDLE) && (h_cnt == CNT_ONE) && !h_evt;
        s_req    = (s_cnt == CNT_ONE) && !s_evt;
        h_gnt    = h_req && !key_req;
        s_gnt    = s_req && !key_req && !h_req;
        push_req = live && (key_req || h_req || s_req);
        push_act = key_req ? key_act : (h_req ? dir : ACT_SOFT);
    end

    // Horizontal DAS/ARR next state; a timer that loses arbitration holds at 1.
    always_comb begin
        h_state_n = h_state;
        h_cnt_n   = h_cnt;
        dir_n     = dir;
        if (!live) begin
            h_state_n = H_IDLE;
            h_cnt_n   = '0;
        end else if (horiz_make) begin
            dir_n     = ev_act;
            h_cnt_n   = DAS_LD;
            h_state_n = H_DAS;
        end else if (dir_brk) begin
            if (opp_held) begin
                dir_n     = opp_dir;
                h_cnt_n   = DAS_LD;
                h_state_n = H_DAS;
            end else begin
                h_cnt_n   = '0;
                h_state_n = H_IDLE;
            end
        end else if (h_state != H_IDLE) begin
            if (h_cnt == CNT_ONE) begin
                if (h_gnt) begin
                    h_cnt_n   = ARR_LD;
                    h_state_n = H_ARR;
                end
            end else begin
                h_cnt_n = h_cnt - CNT_ONE;
            end
        end
    end

    // Soft-drop timer next value; zero means not repeating.
    always_comb begin
        s_cnt_n = s_cnt;
        if (!live)
            s_cnt_n = '0;
        else if ((ev_act == ACT_SOFT) && fresh)
            s_cnt_n = SOFT_LD;
        else if ((ev_act == ACT_SOFT) && ev_brk)
            s_cnt_n = '0;
        else if (s_cnt != '0) begin
            if (s_cnt == CNT_ONE) begin
                if (s_gnt) s_cnt_n = SOFT_LD;
            end else begin
                s_cnt_n = s_cnt - CNT_ONE;
            end
        end
    end

    // Timer and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state <= H_IDLE;
            h_cnt   <= '0;
            dir     <= ACT_NONE;
            s_cnt   <= '0;
        end else begin
            h_state <= h_state_n;
            h_cnt   <= h_cnt_n;
            dir     <= dir_n;
            s_cnt   <= s_cnt_n;
        end
    end

    // Overflow pulses the cycle after a push is refused by a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else
            overflow <= push_req && fifo_full && !pop;
    end

    action_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push_req),
        .din   (push_act),
        .pop   (pop),
        .dout  (action),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_key_action_scheduler.sv
// Self-checking bench: vector table, directed timing sequences and random
// traffic against a timestamp-based reference model.
module tb_key_action_scheduler;
    import tetris_input_pkg::*;

    localparam int DAS   = 20;
    localparam int ARR   = 5;
    localparam int SOFT  = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] code = 8'h00;
    logic       mk = 1'b0;
    logic       vld = 1'b0;
    logic       en = 1'b1;
    logic       fl = 1'b0;
    logic       rdy = 1'b1;
    logic [2:0] action;
    logic       action_valid;
    logic       overflow;

    key_action_scheduler #(
        .DAS_CYCLES  (DAS),
        .ARR_CYCLES  (ARR),
        .SOFT_CYCLES (SOFT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .current_scan_code  (code),
        .current_make_break (mk),
        .key_event_valid    (vld),
        .enable             (en),
        .flush              (fl),
        .action             (action),
        .action_valid       (action_valid),
        .action_ready       (rdy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: queue of action codes, held set, absolute due times.
    int q[$];
    bit held[8];
    bit h_on, s_on, m_ovf;
    int h_dir, h_due, s_due, cyc;

    typedef struct {
        bit         vld;
        logic [7:0] code;
        bit         mk;
        bit         rdy;
        bit         ev;
        int         ea;
        bit         eo;
    } vec_t;

    vec_t tbl[11];
    int   t2_exp[4];
    int   lc[$];
    int   o3[80];
    int   o5[40];
    int   o1[22];
    int   cnt_a, cnt_b, rr;
    logic [7:0] codes[9];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (model cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic int keymap(input logic [7:0] c);
        case (c)
            8'h6B: return 1;
            8'h74: return 2;
            8'h72: return 3;
            8'h29: return 4;
            8'h75: return 5;
            8'h1A: return 6;
            8'h12: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) held[i] = 1'b0;
        h_on = 0; s_on = 0; m_ovf = 0; h_dir = 0; h_due = 0; s_due = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input bit m,
                              input bit e, input bit f, input bit r);
        int a, pa, sz;
        bit fresh, brk, pop;
        a     = v ? keymap(c) : 0;
        fresh = (a != 0) && m && !held[a];
        brk   = (a != 0) && !m;
        pa    = 0;
        if (!(e && !f)) begin
            h_on = 0;
            s_on = 0;
        end else begin
            if (fresh) begin
                pa = a;
                if (a == 1 || a == 2) begin h_on = 1; h_dir = a; h_due = cyc + DAS; end
                if (a == 3) begin s_on = 1; s_due = cyc + SOFT; end
            end else if (brk) begin
                if (a == 3) s_on = 0;
                if (h_on && a == h_dir) begin
                    if (held[3 - a]) begin h_dir = 3 - a; pa = h_dir; h_due = cyc + DAS; end
                    else h_on = 0;
                end
            end
            if (h_on && cyc >= h_due && pa == 0) begin pa = h_dir; h_due = cyc + ARR; end
            if (s_on && cyc >= s_due && pa == 0) begin pa = 3; s_due = cyc + SOFT; end
        end
        sz    = q.size();
        pop   = (sz > 0) && r;
        m_ovf = 0;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (pa != 0) begin
                if (sz < DEPTH || pop) q.push_back(pa);
                else m_ovf = 1;
            end
        end
        if (a != 0) held[a] = m;
        cyc++;
    endtask

    // One clock: drive at negedge, clock edge, advance model, compare at negedge.
    task automatic step(input bit v, input logic [7:0] c, input bit m,
                        input bit e, input bit f, input bit r);
        vld = v; code = c; mk = m; en = e; fl = f; rdy = r;
        @(posedge clk);
        model_step(v, c, m, e, f, r);
        @(negedge clk);
        chk("valid", int'(action_valid), (q.size() > 0) ? 1 : 0);
        chk("action", int'(action), (q.size() > 0) ? q[0] : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
        vld = 1'b0;
    endtask

    task automatic idle(input int n, input bit e, input bit r);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, e, 0, r);
    endtask

    function automatic int obs();
        return action_valid ? int'(action) : 0;
    endfunction

    initial begin
        tbl[0]  = '{1'b1, SC_UP,     1'b1, 1'b0, 1'b1, 5, 1'b0};
        tbl[1]  = '{1'b1, SC_Z,      1'b1, 1'b0, 1'b1, 5, 1'b0};
        tbl[2]  = '{1'b1, SC_SPACE,  1'b1, 1'b0, 1'b1, 5, 1'b0};
        tbl[3]  = '{1'b1, SC_LSHIFT, 1'b1, 1'b0, 1'b1, 5, 1'b0};
        tbl[4]  = '{1'b1, SC_UP,     1'b0, 1'b0, 1'b1, 5, 1'b0};
        tbl[5]  = '{1'b1, SC_UP,     1'b1, 1'b0, 1'b1, 5, 1'b1};
        tbl[6]  = '{1'b0, 8'h00,     1'b0, 1'b0, 1'b1, 5, 1'b0};
        tbl[7]  = '{1'b0, 8'h00,     1'b0, 1'b1, 1'b1, 6, 1'b0};
        tbl[8]  = '{1'b0, 8'h00,     1'b0, 1'b1, 1'b1, 4, 1'b0};
        tbl[9]  = '{1'b0, 8'h00,     1'b0, 1'b1, 1'b1, 7, 1'b0};
        tbl[10] = '{1'b0, 8'h00,     1'b0, 1'b1, 1'b0, 0, 1'b0};
        t2_exp  = '{1, 21, 26, 31};
        codes   = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h1A, 8'h29, 8'h12, 8'hF0, 8'h1C};
        cyc = 0;
        model_reset();

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", int'(action_valid), 0);
        chk("rst_action", int'(action), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot keys fill the queue with ready low, fifth make overflows
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].vld, tbl[i].code, tbl[i].mk, 1, 0, tbl[i].rdy);
            chk("tbl_valid", int'(action_valid), int'(tbl[i].ev));
            chk("tbl_action", int'(action), tbl[i].ea);
            chk("tbl_overflow", int'(overflow), int'(tbl[i].eo));
        end
        step(1, SC_UP, 0, 1, 0, 1);
        step(1, SC_Z, 0, 1, 0, 1);
        step(1, SC_SPACE, 0, 1, 0, 1);
        step(1, SC_LSHIFT, 0, 1, 0, 1);
        idle(2, 1, 1);

        // LEFT hold: DAS then ARR, typematic makes ignored, break stops
        for (int k = 0; k < 46; k++) begin
            if (k == 0 || k == 10 || k == 15) step(1, SC_LEFT, 1, 1, 0, 1);
            else if (k == 33) step(1, SC_LEFT, 0, 1, 0, 1);
            else step(0, 8'h00, 0, 1, 0, 1);
            if (obs() == int'(ACT_LEFT)) lc.push_back(k + 1);
        end
        chk("t2_count", lc.size(), 4);
        for (int i = 0; i < 4 && i < lc.size(); i++) chk("t2_cycle", lc[i], t2_exp[i]);

        // Last pressed direction wins; releasing it falls back with a fresh DAS
        for (int k = 0; k < 80; k++) begin
            if (k == 0) step(1, SC_LEFT, 1, 1, 0, 1);
            else if (k == 27) step(1, SC_RIGHT, 1, 1, 0, 1);
            else if (k == 50) step(1, SC_RIGHT, 0, 1, 0, 1);
            else if (k == 75) step(1, SC_LEFT, 0, 1, 0, 1);
            else step(0, 8'h00, 0, 1, 0, 1);
            o3[k] = obs();
        end
        chk("t3_first_left", o3[0], int'(ACT_LEFT));
        chk("t3_right_now", o3[27], int'(ACT_RIGHT));
        cnt_a = 0;
        for (int k = 28; k < 47; k++) if (o3[k] != 0) cnt_a++;
        chk("t3_right_das_quiet", cnt_a, 0);
        chk("t3_right_repeat", o3[47], int'(ACT_RIGHT));
        chk("t3_left_back", o3[50], int'(ACT_LEFT));
        cnt_a = 0;
        for (int k = 51; k < 70; k++) if (o3[k] != 0) cnt_a++;
        chk("t3_left_das_quiet", cnt_a, 0);
        chk("t3_left_repeat", o3[70], int'(ACT_LEFT));

        // Horizontal and soft timers expire together: LEFT first, SOFT next
        for (int k = 0; k < 40; k++) begin
            if (k == 0) step(1, SC_LEFT, 1, 1, 0, 1);
            else if (k == 17) step(1, SC_DOWN, 1, 1, 0, 1);
            else step(0, 8'h00, 0, 1, 0, 1);
            o5[k] = obs();
        end
        step(1, SC_LEFT, 0, 1, 0, 1);
        step(1, SC_DOWN, 0, 1, 0, 1);
        idle(2, 1, 1);
        chk("t5_tie_left", o5[25], int'(ACT_LEFT));
        chk("t5_tie_soft", o5[26], int'(ACT_SOFT));
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            if (o5[k] == int'(ACT_LEFT)) cnt_a++;
            if (o5[k] == int'(ACT_SOFT)) cnt_b++;
        end
        chk("t5_left_count", cnt_a, 5);
        chk("t5_soft_count", cnt_b, 3);

        // Enable low, flush, and re-enable with a direction still held
        step(1, SC_LEFT, 1, 1, 0, 1);
        chk("t6_left", obs(), int'(ACT_LEFT));
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin step(0, 8'h00, 0, 0, 0, 1); if (action_valid) cnt_a++; end
        chk("t6_disabled_quiet", cnt_a, 0);
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin step(0, 8'h00, 0, 1, 0, 1); if (action_valid) cnt_a++; end
        chk("t6_reenabled_quiet", cnt_a, 0);
        step(1, SC_Z, 1, 1, 0, 0);
        step(1, SC_SPACE, 1, 1, 0, 0);
        step(1, SC_LSHIFT, 1, 1, 0, 0);
        chk("t6_three_queued", obs(), int'(ACT_ROT_CCW));
        step(1, SC_UP, 1, 1, 1, 0);
        chk("t6_flush_valid", int'(action_valid), 0);
        chk("t6_flush_action", int'(action), 0);
        step(1, SC_UP, 1, 1, 0, 0);
        chk("t6_flush_held_kept", int'(action_valid), 0);
        step(1, SC_UP, 0, 1, 0, 0);
        step(1, SC_UP, 1, 1, 0, 0);
        chk("t6_up_fresh", obs(), int'(ACT_ROT_CW));
        step(1, SC_UP, 0, 1, 0, 1);
        step(1, SC_Z, 0, 1, 0, 1);
        step(1, SC_SPACE, 0, 1, 0, 1);
        step(1, SC_LSHIFT, 0, 1, 0, 1);
        step(1, SC_LEFT, 0, 1, 0, 1);
        step(1, SC_LEFT, 1, 1, 0, 1);
        chk("t6_fresh_left", obs(), int'(ACT_LEFT));
        step(1, SC_LEFT, 0, 1, 0, 1);
        idle(2, 1, 1);

        // Asynchronous reset in the middle of ARR with a queued move
        step(1, SC_LEFT, 1, 1, 0, 1);
        idle(27, 1, 1);
        idle(3, 1, 0);
        chk("t1_pre_valid", int'(action_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", int'(action_valid), 0);
        chk("t1_rst_action", int'(action), 0);
        chk("t1_rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 22; k++) begin
            if (k == 0) step(1, SC_RIGHT, 1, 1, 0, 1);
            else step(0, 8'h00, 0, 1, 0, 1);
            o1[k] = obs();
        end
        chk("t1_right_first", o1[0], int'(ACT_RIGHT));
        cnt_a = 0;
        for (int k = 1; k < 20; k++) if (o1[k] != 0) cnt_a++;
        chk("t1_das_quiet", cnt_a, 0);
        chk("t1_right_repeat", o1[20], int'(ACT_RIGHT));
        step(1, SC_RIGHT, 0, 1, 0, 1);

        // Random traffic against the reference model
        for (int k = 0; k < 2000; k++) begin
            rr = ((k / 200) % 2 == 1) ? 3 : 1;
            step(($urandom_range(0, 99) < 25), codes[$urandom_range(0, 8)],
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) < rr));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
